bluemax_ram_arbiter: RTL
========================

BLUEMAX_RAM_ARBITER -- requirements
Module: bluemax_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word-address width (4096 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have master ports mN_* for N=0,1: mN_address in ADDR_W; mN_byteenable in 4; mN_read in 1; mN_write in 1; mN_writedata in DATA_W.
REQ-005 SHALL have master outputs mN_waitrequest out 1, command stalled; mN_readdata out DATA_W; mN_readdatavalid out 1, read data strobe.
REQ-006 SHALL have RAM-side ports: ram_address out ADDR_W; ram_byteenable out 4; ram_chipselect out 1; ram_write out 1; ram_writedata out DATA_W; ram_readdata in DATA_W.

Function
REQ-007 SHALL treat master N as requesting when mN_read | mN_write is high.
REQ-008 SHALL grant at most one master per cycle; the grant is combinational from requests and priority state.
REQ-009 SHALL hold a 2-state priority FSM: PRI_M0 (m0 wins ties), PRI_M1 (m1 wins ties).
REQ-010 Sole requester SHALL be granted regardless of FSM state.
REQ-011 After any cycle granting m0, FSM SHALL go to PRI_M1; after a cycle granting m1, to PRI_M0; with no grant, FSM SHALL hold.
REQ-012 mN_waitrequest SHALL equal request_N & ~grant_N; it SHALL be 0 when master N is idle.
REQ-013 Granted master's address, byteenable, writedata SHALL drive ram_*; ram_chipselect = any grant; ram_write = granted master's write.
REQ-014 With no grant, ram_chipselect and ram_write SHALL be 0; ram_address, ram_byteenable and ram_writedata SHALL hold m0's values (don't-care).
REQ-015 If a master asserts read and write together, the access SHALL be a write; no readdatavalid is produced.
REQ-016 For a granted read, the arbiter SHALL register a pending flag and owner ID; in the following cycle mN_readdatavalid of the owner SHALL be 1 for exactly one cycle.
REQ-017 Read latency SHALL be fixed at 1 cycle after grant; back-to-back reads, from one or alternating masters, SHALL be accepted every cycle with no bubble.
REQ-018 mN_readdata SHALL be wired from ram_readdata to both masters; only readdatavalid qualifies it.
REQ-019 Writes SHALL complete in the grant cycle; no response is produced.
REQ-020 A read and a write to the same address in consecutive cycles SHALL be passed in grant order; read-during-write data is undefined, matching the RAM.
REQ-021 Address range SHALL wrap naturally at 2^ADDR_W; no range checking.

Reset
REQ-022 On reset, the FSM SHALL go to PRI_M0 and the pending flag SHALL be cleared; readdatavalid outputs SHALL be 0 the cycle after reset asserts.
REQ-023 A read granted in the cycle reset is asserted SHALL produce no readdatavalid.
REQ-024 While reset is high, ram_chipselect, ram_write and both mN_waitrequest SHALL be 1-safe: chipselect=0, write=0, waitrequest=request_N.

Structure
REQ-025 Package bluemax_ram_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the BE width constant, and the master-ID and priority-state typedefs.
REQ-026 The block SHALL be a single module with no sub-module; the RAM is instantiated outside, alongside it.

Verification
REQ-027 Reset, then m0 write 0x0A5 = 0xDEADBEEF, byteenable 0xF -> ram_chipselect=1, ram_write=1 same cycle, m0_waitrequest=0.
REQ-028 m0 and m1 read simultaneously after reset, addresses 0x0A5 and 0x001 -> m0 granted cycle 0, m1 stalled one cycle; m0_readdatavalid at cycle 1 with 0xDEADBEEF, m1_readdatavalid at cycle 2.
REQ-029 Both masters read continuously for 8 cycles -> grants alternate m0,m1,...; each gets 4 readdatavalid pulses; no idle RAM cycle.
REQ-030 m1 byte write 0x000=0x000000FF with byteenable 0x1 over prior 0x12345600, then m0 reads 0x000 -> m0_readdata=0x123456FF.
REQ-031 m0 reads at 0xFFF, reset asserted the same cycle -> no readdatavalid; after release, m0 wins a tie (PRI_M0).
REQ-032 m1 asserts read and write together to 0x010 = 0x55 -> RAM write occurs, m1_readdatavalid stays 0.

Source files
------------

// File: rtl/bluemax_ram_arb_pkg.sv
// Shared constants and types for the two-master single-port RAM arbiter.
package bluemax_ram_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned BE_W       = DATA_W_DEF / 8;

   typedef enum logic {
      MASTER_0 = 1'b0,
      MASTER_1 = 1'b1
   } master_id_t;

   typedef enum logic {
      PRI_M0 = 1'b0,
      PRI_M1 = 1'b1
   } pri_state_t;

endpackage

// File: rtl/bluemax_ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM with 1-cycle read latency.
// Alternating tie-break priority; read responses are routed back by a registered owner tag.
module bluemax_ram_arbiter
   import bluemax_ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,

   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W-1:0]     ram_writedata,
   input  logic [DATA_W-1:0]     ram_readdata
);

   pri_state_t state_q, state_d;
   master_id_t owner_q, owner_d;
   logic       pending_q, pending_d;
   logic       req0, req1;
   logic       gnt0, gnt1;

   // Grant, next priority state and RAM command mux; no grant while reset is high.
   always_comb begin
      req0           = m0_read | m0_write;
      req1           = m1_read | m1_write;
      gnt0           = 1'b0;
      gnt1           = 1'b0;
      state_d        = state_q;
      pending_d      = 1'b0;
      owner_d        = MASTER_0;
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
      ram_write      = 1'b0;

      if (!reset) begin
         if (req0 && (!req1 || state_q == PRI_M0)) begin
            gnt0 = 1'b1;
         end else if (req1) begin
            gnt1 = 1'b1;
         end
      end

      if (gnt0) begin
         state_d   = PRI_M1;
         ram_write = m0_write;
         pending_d = m0_read & ~m0_write;
      end else if (gnt1) begin
         state_d        = PRI_M0;
         owner_d        = MASTER_1;
         ram_address    = m1_address;
         ram_byteenable = m1_byteenable;
         ram_writedata  = m1_writedata;
         ram_write      = m1_write;
         pending_d      = m1_read & ~m1_write;
      end

      ram_chipselect = gnt0 | gnt1;
      m0_waitrequest = req0 & ~gnt0;
      m1_waitrequest = req1 & ~gnt1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= PRI_M0;
         pending_q <= 1'b0;
         owner_q   <= MASTER_0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         owner_q   <= owner_d;
      end
   end

   // Read data is shared; the strobe alone tells the owner its word has arrived.
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;
   assign m0_readdatavalid = pending_q & (owner_q == MASTER_0);
   assign m1_readdatavalid = pending_q & (owner_q == MASTER_1);

endmodule
